// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory access controller: bus widths,
// FSM state encoding and requester (owner) encoding.
package mem_access_ctrl_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Bundle of the fetch port, load/store port and memory-side signals.
// Handshake rule for every req/rsp channel: a transfer happens at a rising
// edge where valid and ready are both 1; once valid is raised the sender
// holds valid and payload unchanged until that transfer, and ready may be
// high before valid without effect.
interface mem_access_ctrl_if #(
  parameter int ADDR_W = mem_access_ctrl_pkg::ADDR_W,
  parameter int DATA_W = mem_access_ctrl_pkg::DATA_W
) ();

  logic              i_req_valid;
  logic              i_req_ready;
  logic [ADDR_W-1:0] i_req_addr;
  logic              i_rsp_valid;
  logic              i_rsp_ready;
  logic [DATA_W-1:0] i_rsp_data;

  logic              d_req_valid;
  logic              d_req_ready;
  logic              d_req_we;
  logic [ADDR_W-1:0] d_req_addr;
  logic [DATA_W-1:0] d_req_wdata;
  logic              d_rsp_valid;
  logic              d_rsp_ready;
  logic [DATA_W-1:0] d_rsp_data;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Controller view.
  modport master (
    input  i_req_valid, i_req_addr, i_rsp_ready,
    input  d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_rsp_ready,
    input  mem_rdata,
    output i_req_ready, i_rsp_valid, i_rsp_data,
    output d_req_ready, d_rsp_valid, d_rsp_data,
    output mem_we, mem_addr, mem_wdata
  );

  // Requester and memory view.
  modport slave (
    output i_req_valid, i_req_addr, i_rsp_ready,
    output d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_rsp_ready,
    output mem_rdata,
    input  i_req_ready, i_rsp_valid, i_rsp_data,
    input  d_req_ready, d_rsp_valid, d_rsp_data,
    input  mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_access_ctrl_arb.sv
// Two-way alternating-priority arbiter between fetch (I) and load/store (D).
// With both requesters valid, the one not granted last wins; a lone
// requester is always served. Readies are only offered while idle.
module mem_arb2 import mem_access_ctrl_pkg::*; (
  input  logic   clk,
  input  logic   rst,
  input  logic   i_valid,
  input  logic   d_valid,
  input  logic   idle,
  input  logic   accept,
  output logic   i_ready,
  output logic   d_ready,
  output owner_t grant
);

  owner_t last_grant;

  assign d_ready = idle & ~(i_valid & (last_grant == OWN_D));
  assign i_ready = idle & (~d_valid | (last_grant == OWN_D));
  assign grant   = (d_valid & d_ready) ? OWN_D : OWN_I;

  // Remember who won the most recent accept so the next tie flips.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= OWN_I;
    end else if (accept) begin
      last_grant <= grant;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Initiator for the single-port synchronous memory. Accepts one request at a
// time from fetch or load/store, drives registered memory controls, captures
// the read word one cycle after the memory samples the address, and returns
// it on the owner's response channel. Stores return the prior contents.
module mem_access_ctrl import mem_access_ctrl_pkg::*; (
  input  logic                 clk,
  input  logic                 rst,
  mem_access_ctrl_if.master    bus,
  output state_t               state_dbg
);

  state_t state;
  state_t state_nxt;
  owner_t owner;
  owner_t grant;
  logic   idle;
  logic   accept;
  logic   i_ready;
  logic   d_ready;
  logic   rsp_done;

  assign idle      = (state == ST_IDLE);
  assign state_dbg = state;

  mem_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .i_valid (bus.i_req_valid),
    .d_valid (bus.d_req_valid),
    .idle    (idle),
    .accept  (accept),
    .i_ready (i_ready),
    .d_ready (d_ready),
    .grant   (grant)
  );

  assign bus.i_req_ready = i_ready;
  assign bus.d_req_ready = d_ready;
  assign accept   = (bus.i_req_valid & i_ready) | (bus.d_req_valid & d_ready);
  assign rsp_done = (owner == OWN_D) ? (bus.d_rsp_valid & bus.d_rsp_ready)
                                     : (bus.i_rsp_valid & bus.i_rsp_ready);

  // State register; reset drops any in-flight transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: one pass through issue/capture/respond per accepted request.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (accept) state_nxt = ST_ISSUE;
      ST_ISSUE:   state_nxt = ST_CAPTURE;
      ST_CAPTURE: state_nxt = ST_RESP;
      ST_RESP:    if (rsp_done) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Memory control and response registers. mem_we is high only for the
  // single edge at which the memory samples the store, so a store writes once.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner           <= OWN_I;
      bus.mem_we      <= 1'b0;
      bus.mem_addr    <= '0;
      bus.mem_wdata   <= '0;
      bus.i_rsp_valid <= 1'b0;
      bus.i_rsp_data  <= '0;
      bus.d_rsp_valid <= 1'b0;
      bus.d_rsp_data  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            owner <= grant;
            if (grant == OWN_D) begin
              bus.mem_addr  <= bus.d_req_addr;
              bus.mem_we    <= bus.d_req_we;
              bus.mem_wdata <= bus.d_req_wdata;
            end else begin
              bus.mem_addr  <= bus.i_req_addr;
              bus.mem_we    <= 1'b0;
            end
          end
        end
        ST_ISSUE: begin
          bus.mem_we <= 1'b0;
        end
        ST_CAPTURE: begin
          if (owner == OWN_D) begin
            bus.d_rsp_data  <= bus.mem_rdata;
            bus.d_rsp_valid <= 1'b1;
          end else begin
            bus.i_rsp_data  <= bus.mem_rdata;
            bus.i_rsp_valid <= 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_done) begin
            bus.i_rsp_valid <= 1'b0;
            bus.d_rsp_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
